// File: rtl/div_hilo_ctrl_pkg.sv
// Shared constants for the divider/HI-LO sequencing controller:
// EX-stage function codes, result-mux encodings and FSM states.
package div_hilo_ctrl_pkg;

    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_DIVU = 6'd27;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [1:0] SEL_LO  = 2'd2;
    localparam logic [1:0] SEL_SHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_hilo_ctrl_counter.sv
// Loadable down-counter with zero flag that times the divider iterations.
// Saturates at zero so it can never wrap.
module div_latency_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             isZero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign isZero = (count == '0);

endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequences a DIVU through the multi-cycle divider, strobes the HI/LO write,
// stalls dependent instructions and decodes the result-mux select.
module div_hilo_ctrl
    import div_hilo_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataB,
    output logic        div_start,
    output logic        hilo_we,
    output logic        busy,
    output logic        stall,
    output logic [1:0]  mux_sel,
    output logic        div_by_zero
);

    divState_t        state;
    logic             accept;
    logic             cntZero;
    logic [CNT_W-1:0] cnt;

    assign accept = (state == ST_IDLE) && ex_valid && !ex_flush && (Signal == FN_DIVU);

    div_latency_counter #(
        .CNT_W (CNT_W)
    ) uCounter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .loadValue (CNT_W'(DIV_CYCLES - 1)),
        .dec       (state == ST_RUN),
        .count     (cnt),
        .isZero    (cntZero)
    );

    // div_start, hilo_we and busy are registered so each lines up with the
    // state it belongs to: start in the first RUN cycle, write in WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            div_start   <= 1'b0;
            hilo_we     <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_start <= 1'b0;
            hilo_we   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_RUN;
                        div_start   <= 1'b1;
                        busy        <= 1'b1;
                        div_by_zero <= (dataB == '0);
                    end
                end
                ST_RUN: begin
                    if (cntZero) begin
                        state   <= ST_WRITE;
                        hilo_we <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall = ex_valid && !ex_flush && busy &&
                (Signal inside {FN_DIVU, FN_MFHI, FN_MFLO});
    end

    always_comb begin
        mux_sel = SEL_ALU;
        unique case (Signal)
            FN_MFHI: mux_sel = SEL_HI;
            FN_MFLO: mux_sel = SEL_LO;
            FN_SLL:  mux_sel = SEL_SHT;
            default: mux_sel = SEL_ALU;
        endcase
    end

endmodule
